// File: rtl/xyolo_lanes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xyolo_lanes_pkg
// Description : Shared constants and FSM state encoding for the xyolo_lanes
//               multi-lane MAC / post-processing block.
// Contents    : default parameter constants, maximum pool window, state_t
// Revision    : 1.0 - initial release
// ============================================================================
package xyolo_lanes_pkg;

  localparam int c_DATA_W   = 16;
  localparam int c_N_LANES  = 4;
  localparam int c_SHIFT_W  = 5;
  localparam int c_CNT_W    = 12;
  localparam int c_LEAKY_SH = 3;
  localparam int c_MP_MAX   = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACC   = 3'd1,
    S_DRAIN = 3'd2,
    S_POST  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/xyolo_lane.sv
`default_nettype none
// ============================================================================
// Module      : xyolo_lane
// Description : One MAC lane: registered signed product, wide accumulator with
//               optional bias seed, shift/saturate/leaky post-processing and a
//               max-pool result register.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               beat_en, beat_first - accepted input beat / first beat of result
//               pixel, weight, bias - signed lane operands
//               cfg_*               - latched job configuration
//               post_en, pool_first - POST cycle strobe / start of pool window
//               result              - pooled (or single) lane result
// Revision    : 1.0 - initial release
// ============================================================================
module xyolo_lane
  import xyolo_lanes_pkg::*;
#(
  parameter int DATA_W   = c_DATA_W,
  parameter int SHIFT_W  = c_SHIFT_W,
  parameter int CNT_W    = c_CNT_W,
  parameter int LEAKY_SH = c_LEAKY_SH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               beat_en,
  input  logic               beat_first,
  input  logic [DATA_W-1:0]  pixel,
  input  logic [DATA_W-1:0]  weight,
  input  logic [DATA_W-1:0]  bias,
  input  logic               cfg_bias,
  input  logic               cfg_leaky,
  input  logic               cfg_bypass,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic               post_en,
  input  logic               pool_first,
  output logic [DATA_W-1:0]  result
);

  localparam int c_PROD_W = 2 * DATA_W;
  localparam int c_ACC_W  = c_PROD_W + CNT_W;

  logic signed [c_PROD_W-1:0] w_pix_ext, w_wt_ext, w_prod;
  logic signed [c_ACC_W-1:0]  w_bias_ext, w_seed, w_prod_ext, w_shifted;
  logic        [c_ACC_W-DATA_W:0] w_hi;
  logic                       w_fits;
  logic signed [DATA_W-1:0]   w_sat, w_leak, w_value;

  logic                       r_p1_vld, r_p1_first;
  logic signed [c_PROD_W-1:0] r_prod;
  logic signed [c_ACC_W-1:0]  r_seed, r_acc;
  logic signed [DATA_W-1:0]   r_last_pix, r_pool;

  // Operands are sign-extended to full product width so the low 2*DATA_W
  // bits of the product are the exact signed result.
  assign w_pix_ext  = {{DATA_W{pixel[DATA_W-1]}}, pixel};
  assign w_wt_ext   = {{DATA_W{weight[DATA_W-1]}}, weight};
  assign w_prod     = w_pix_ext * w_wt_ext;

  // Bias is pre-scaled so that the later >>> cfg_shift leaves it at unit weight.
  assign w_bias_ext = {{(c_ACC_W-DATA_W){bias[DATA_W-1]}}, bias};
  assign w_seed     = cfg_bias ? (w_bias_ext <<< cfg_shift) : '0;
  assign w_prod_ext = {{CNT_W{r_prod[c_PROD_W-1]}}, r_prod};

  // Result fits DATA_W when all bits above the DATA_W sign bit agree with it.
  assign w_shifted = r_acc >>> cfg_shift;
  assign w_hi      = w_shifted[c_ACC_W-1:DATA_W-1];
  assign w_fits    = (&w_hi) | ~(|w_hi);
  assign w_sat     = w_fits ? w_shifted[DATA_W-1:0] :
                     (w_shifted[c_ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                           : {1'b0, {(DATA_W-1){1'b1}}});
  assign w_leak    = (cfg_leaky && w_sat[DATA_W-1]) ? (w_sat >>> LEAKY_SH) : w_sat;
  assign w_value   = cfg_bypass ? r_last_pix : w_leak;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p1_vld   <= 1'b0;
      r_p1_first <= 1'b0;
      r_prod     <= '0;
      r_seed     <= '0;
      r_acc      <= '0;
      r_last_pix <= '0;
      r_pool     <= '0;
    end else begin
      r_p1_vld <= beat_en;
      if (beat_en) begin
        r_prod     <= w_prod;
        r_p1_first <= beat_first;
        r_seed     <= w_seed;
        r_last_pix <= pixel;
      end
      if (r_p1_vld) begin
        r_acc <= (r_p1_first ? r_seed : r_acc) + w_prod_ext;
      end
      if (post_en && (pool_first || (w_value > r_pool))) begin
        r_pool <= w_value;
      end
    end
  end

  assign result = r_pool;

endmodule
`default_nettype wire

// File: rtl/xyolo_lanes.sv
`default_nettype none
// ============================================================================
// Module      : xyolo_lanes
// Description : N_LANES parallel signed MAC lanes with bias, fixed-point shift,
//               saturation, leaky activation, max-pooling and bypass. Holds the
//               job FSM (IDLE/ACC/DRAIN/POST/OUT) and the beat/pool/output
//               counters; per-lane datapath lives in xyolo_lane.
// Ports       : clk, rst                  - clock, synchronous active-high reset
//               start, cfg_*              - job start pulse and configuration
//               in_valid/in_ready, in_*   - input beat handshake and lane data
//               out_valid/out_ready       - output handshake
//               out_data                  - per-lane results
//               busy, done                - job status
// Revision    : 1.0 - initial release
// ============================================================================
module xyolo_lanes
  import xyolo_lanes_pkg::*;
#(
  parameter int DATA_W   = c_DATA_W,
  parameter int N_LANES  = c_N_LANES,
  parameter int SHIFT_W  = c_SHIFT_W,
  parameter int CNT_W    = c_CNT_W,
  parameter int LEAKY_SH = c_LEAKY_SH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [CNT_W-1:0]          cfg_n_acc,
  input  logic [CNT_W-1:0]          cfg_n_out,
  input  logic [2:0]                cfg_mp_win,
  input  logic                      cfg_bias,
  input  logic                      cfg_leaky,
  input  logic                      cfg_maxpool,
  input  logic                      cfg_bypass,
  input  logic [SHIFT_W-1:0]        cfg_shift,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_LANES*DATA_W-1:0] in_pixel,
  input  logic [N_LANES*DATA_W-1:0] in_weight,
  input  logic [N_LANES*DATA_W-1:0] in_bias,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_LANES*DATA_W-1:0] out_data,
  output logic                      busy,
  output logic                      done
);

  state_t r_state, w_next;

  logic [CNT_W-1:0]   r_n_acc, r_n_out, r_beat_cnt, r_out_cnt;
  logic [2:0]         r_mp_win, r_mp_cnt;
  logic               r_bias, r_leaky, r_maxpool, r_bypass;
  logic [SHIFT_W-1:0] r_shift;
  logic               r_drain, r_done;

  logic w_accept, w_last_beat, w_last_pool, w_last_out, w_pool_first;

  assign w_accept     = in_valid && (r_state == S_ACC);
  assign w_last_beat  = (r_beat_cnt == r_n_acc - CNT_W'(1));
  assign w_last_pool  = (r_mp_cnt == r_mp_win - 3'd1);
  assign w_last_out   = (r_out_cnt == r_n_out - CNT_W'(1));
  assign w_pool_first = !r_maxpool || (r_mp_cnt == 3'd0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:  if (start) w_next = S_ACC;
      S_ACC: begin
        in_ready = 1'b1;
        if (in_valid && w_last_beat) w_next = S_DRAIN;
      end
      // Two cycles let the product and accumulate stages settle.
      S_DRAIN: if (r_drain) w_next = S_POST;
      S_POST:  w_next = (!r_maxpool || w_last_pool) ? S_OUT : S_ACC;
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_next = w_last_out ? S_IDLE : S_ACC;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_n_acc    <= '0;
      r_n_out    <= '0;
      r_mp_win   <= '0;
      r_bias     <= 1'b0;
      r_leaky    <= 1'b0;
      r_maxpool  <= 1'b0;
      r_bypass   <= 1'b0;
      r_shift    <= '0;
      r_beat_cnt <= '0;
      r_out_cnt  <= '0;
      r_mp_cnt   <= '0;
      r_drain    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_drain <= (r_state == S_DRAIN) ? ~r_drain : 1'b0;
      if (r_state == S_IDLE && start) begin
        r_n_acc    <= (cfg_n_acc == '0) ? CNT_W'(1) : cfg_n_acc;
        r_n_out    <= (cfg_n_out == '0) ? CNT_W'(1) : cfg_n_out;
        r_mp_win   <= (cfg_mp_win == 3'd0) ? 3'd1 :
                      ((cfg_mp_win > 3'(c_MP_MAX)) ? 3'(c_MP_MAX) : cfg_mp_win);
        r_bias     <= cfg_bias;
        r_leaky    <= cfg_leaky;
        r_maxpool  <= cfg_maxpool;
        r_bypass   <= cfg_bypass;
        r_shift    <= cfg_shift;
        r_beat_cnt <= '0;
        r_out_cnt  <= '0;
        r_mp_cnt   <= '0;
      end
      if (w_accept) begin
        r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + CNT_W'(1);
      end
      if (r_state == S_POST && r_maxpool) begin
        r_mp_cnt <= w_last_pool ? 3'd0 : r_mp_cnt + 3'd1;
      end
      if (r_state == S_OUT && out_ready) begin
        r_out_cnt <= r_out_cnt + CNT_W'(1);
        if (w_last_out) r_done <= 1'b1;
      end
    end
  end

  assign done = r_done;

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    xyolo_lane #(
      .DATA_W   (DATA_W),
      .SHIFT_W  (SHIFT_W),
      .CNT_W    (CNT_W),
      .LEAKY_SH (LEAKY_SH)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .beat_en    (w_accept),
      .beat_first (r_beat_cnt == '0),
      .pixel      (in_pixel[g*DATA_W +: DATA_W]),
      .weight     (in_weight[g*DATA_W +: DATA_W]),
      .bias       (in_bias[g*DATA_W +: DATA_W]),
      .cfg_bias   (r_bias),
      .cfg_leaky  (r_leaky),
      .cfg_bypass (r_bypass),
      .cfg_shift  (r_shift),
      .post_en    (r_state == S_POST),
      .pool_first (w_pool_first),
      .result     (out_data[g*DATA_W +: DATA_W])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_xyolo_lanes.sv
`default_nettype none
// ============================================================================
// Module      : tb_xyolo_lanes
// Description : Self-checking bench for xyolo_lanes (DATA_W=16, N_LANES=2):
//               directed vector table, hand-written backpressure and mid-job
//               reset sequences, and randomized jobs against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xyolo_lanes;

  localparam int DW = 16;
  localparam int NL = 2;
  localparam int SW = 5;
  localparam int CW = 12;
  localparam int LS = 3;
  localparam int NW = DW * NL;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, out_ready;
  logic [CW-1:0] cfg_n_acc, cfg_n_out;
  logic [2:0]    cfg_mp_win;
  logic          cfg_bias, cfg_leaky, cfg_maxpool, cfg_bypass;
  logic [SW-1:0] cfg_shift;
  logic [NW-1:0] in_pixel, in_weight, in_bias, out_data;
  logic          in_ready, out_valid, busy, done;

  always #5 clk = ~clk;

  xyolo_lanes #(.DATA_W(DW), .N_LANES(NL), .SHIFT_W(SW), .CNT_W(CW), .LEAKY_SH(LS)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_n_acc(cfg_n_acc), .cfg_n_out(cfg_n_out), .cfg_mp_win(cfg_mp_win),
    .cfg_bias(cfg_bias), .cfg_leaky(cfg_leaky), .cfg_maxpool(cfg_maxpool),
    .cfg_bypass(cfg_bypass), .cfg_shift(cfg_shift),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .in_weight(in_weight), .in_bias(in_bias),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  typedef struct {
    int n_acc, n_out, mp_win, shift;
    bit bias, leaky, maxpool, bypass;
  } cfg_t;

  typedef struct {
    string name;
    cfg_t  c;
    int    nb;
    int    p[4];
    int    w[4];
    int    bias;
    int    exp_val;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [NW-1:0] q_pix[$], q_wt[$], q_bias[$], q_exp[$];
  vec_t tbl[$];
  int gap_cyc, hs_done_cyc;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [NW-1:0] got, input logic [NW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic int lane_val(input logic [NW-1:0] v, input int lane);
    logic [DW-1:0] s;
    s = v[lane*DW +: DW];
    return int'($signed(s));
  endfunction

  // Reference: one result from n consecutive beats, straight from the arithmetic rules.
  function automatic int model_value(input cfg_t c, input int base, input int n, input int lane);
    longint acc;
    if (c.bypass) return lane_val(q_pix[base+n-1], lane);
    acc = c.bias ? longint'(lane_val(q_bias[base], lane)) * (longint'(1) << c.shift) : 0;
    for (int j = 0; j < n; j++)
      acc += longint'(lane_val(q_pix[base+j], lane)) * longint'(lane_val(q_wt[base+j], lane));
    acc = acc >>> c.shift;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    if (c.leaky && acc < 0) acc = acc >>> LS;
    return int'(acc);
  endfunction

  function automatic int eff_nacc(input cfg_t c); return (c.n_acc == 0) ? 1 : c.n_acc; endfunction
  function automatic int eff_nout(input cfg_t c); return (c.n_out == 0) ? 1 : c.n_out; endfunction
  function automatic int eff_mpw(input cfg_t c);
    if (!c.maxpool) return 1;
    return (c.mp_win == 0) ? 1 : ((c.mp_win > 4) ? 4 : c.mp_win);
  endfunction

  function automatic void build_expect(input cfg_t c);
    int nacc, mpw, best, v;
    logic [NW-1:0] e;
    nacc = eff_nacc(c);
    mpw  = eff_mpw(c);
    q_exp.delete();
    for (int o = 0; o < eff_nout(c); o++) begin
      e = '0;
      for (int l = 0; l < NL; l++) begin
        best = 0;
        for (int r = 0; r < mpw; r++) begin
          v = model_value(c, (o*mpw + r)*nacc, nacc, l);
          if (r == 0 || v > best) best = v;
        end
        e[l*DW +: DW] = DW'(best);
      end
      q_exp.push_back(e);
    end
  endfunction

  task automatic drive_cfg(input cfg_t c);
    cfg_n_acc   = CW'(c.n_acc);
    cfg_n_out   = CW'(c.n_out);
    cfg_mp_win  = 3'(c.mp_win);
    cfg_shift   = SW'(c.shift);
    cfg_bias    = c.bias;
    cfg_leaky   = c.leaky;
    cfg_maxpool = c.maxpool;
    cfg_bypass  = c.bypass;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_job(input cfg_t c, input string name, input int rdy_pct, input bit noise);
    logic [NW-1:0] got[$];
    int idx, cyc, last_acc, first_vld, last_hs;
    bit fin;
    idx = 0; cyc = 0; fin = 0; last_acc = -1; first_vld = -1; last_hs = -1;
    @(negedge clk);
    drive_cfg(c);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!fin && cyc < 4000) begin
      in_valid = (idx < q_pix.size());
      if (in_valid) begin
        in_pixel  = q_pix[idx];
        in_weight = q_wt[idx];
        in_bias   = q_bias[idx];
      end
      out_ready = ($urandom_range(99) < rdy_pct);
      start     = 1'b0;
      if (noise && busy) begin
        start       = 1'($urandom_range(1));
        cfg_n_acc   = CW'($urandom);
        cfg_n_out   = CW'($urandom);
        cfg_mp_win  = 3'($urandom);
        cfg_shift   = SW'($urandom);
        cfg_bias    = 1'($urandom);
        cfg_leaky   = 1'($urandom);
        cfg_maxpool = 1'($urandom);
        cfg_bypass  = 1'($urandom);
      end
      #1;
      if (in_valid && in_ready) begin
        idx++;
        if (first_vld < 0) last_acc = cyc;
      end
      if (out_valid && first_vld < 0) first_vld = cyc;
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        last_hs = cyc;
      end
      @(negedge clk);
      cyc++;
      if (done) fin = 1'b1;
    end
    in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
    gap_cyc     = first_vld - last_acc;
    hs_done_cyc = cyc - last_hs;
    check({name, "_finished"}, fin, 1);
    check({name, "_beats_used"}, idx, q_pix.size());
    check({name, "_n_outputs"}, got.size(), q_exp.size());
    for (int i = 0; i < got.size() && i < q_exp.size(); i++)
      check_vec($sformatf("%s_out%0d", name, i), got[i], q_exp[i]);
    if (fin) begin
      check({name, "_done_delay"}, hs_done_cyc, 1);
      @(negedge clk);
      check({name, "_done_width"}, done, 0);
    end else begin
      do_reset();
    end
  endtask

  task automatic add_vec(input string name, input int n_acc, input int mp_win, input int shift,
                         input bit b, input bit lk, input bit mp, input bit bp, input int nb,
                         input int p0, input int p1, input int p2, input int p3,
                         input int w0, input int w1, input int w2, input int w3,
                         input int bias, input int exp_val);
    vec_t v;
    v.name = name;
    v.c.n_acc = n_acc; v.c.n_out = 1; v.c.mp_win = mp_win; v.c.shift = shift;
    v.c.bias = b; v.c.leaky = lk; v.c.maxpool = mp; v.c.bypass = bp;
    v.nb = nb;
    v.p[0] = p0; v.p[1] = p1; v.p[2] = p2; v.p[3] = p3;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.bias = bias; v.exp_val = exp_val;
    tbl.push_back(v);
  endtask

  task automatic load_vec(input vec_t v);
    q_pix.delete(); q_wt.delete(); q_bias.delete(); q_exp.delete();
    for (int k = 0; k < v.nb; k++) begin
      q_pix.push_back({NL{DW'(v.p[k])}});
      q_wt.push_back({NL{DW'(v.w[k])}});
      q_bias.push_back({NL{DW'(v.bias)}});
    end
    q_exp.push_back({NL{DW'(v.exp_val)}});
  endtask

  function automatic int rand_val();
    if ($urandom_range(3) == 0) return lane_val(NW'($urandom), 0);
    return int'($urandom_range(60)) - 30;
  endfunction

  initial begin
    logic [NW-1:0] held;
    cfg_t c;
    int nb, wait_cyc;
    bit quiet;

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pixel = '0; in_weight = '0; in_bias = '0;
    c = '{default: 0};
    drive_cfg(c);
    repeat (3) @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check_vec("reset_out_data", out_data, '0);
    rst = 1'b0;

    //       name            nacc mpw sh  b  lk mp bp nb  pixels              weights         bias exp
    add_vec("bias_shift",     3,  0,  2,  1, 0, 0, 0, 3,  2,   3,  4, 0,     5,   6, 7, 0,    10,  24);
    add_vec("leaky_on",       1,  0,  0,  0, 1, 0, 0, 1, -8,   0,  0, 0,    10,   0, 0, 0,     0, -10);
    add_vec("leaky_off",      1,  0,  0,  0, 0, 0, 0, 1, -8,   0,  0, 0,    10,   0, 0, 0,     0, -80);
    add_vec("sat_pos",        1,  0,  0,  0, 0, 0, 0, 1, 300,  0,  0, 0,   300,   0, 0, 0,     0, 32767);
    add_vec("sat_neg",        1,  0,  0,  0, 0, 0, 0, 1, -300, 0,  0, 0,   300,   0, 0, 0,     0, -32768);
    add_vec("sat_neg_leaky",  1,  0,  0,  0, 1, 0, 0, 1, -300, 0,  0, 0,   300,   0, 0, 0,     0, -4096);
    add_vec("maxpool4",       1,  4,  0,  0, 0, 1, 0, 4,  5,  -3,  9, 7,     1,   1, 1, 1,     0,   9);
    add_vec("bypass",         2,  0,  1,  1, 1, 0, 1, 2,  7, -12,  0, 0,   100, 100, 0, 0,     5, -12);
    add_vec("nacc_zero",      0,  0,  0,  0, 0, 0, 0, 1,  6,   0,  0, 0,     7,   0, 0, 0,     0,  42);

    foreach (tbl[i]) begin
      load_vec(tbl[i]);
      run_job(tbl[i].c, tbl[i].name, 100, 0);
      if (i == 0) check("bias_shift_latency", gap_cyc, 4);
    end

    // Backpressure: output held for 5 cycles with out_ready low.
    c = '{default: 0};
    c.n_acc = 1; c.n_out = 1;
    @(negedge clk);
    drive_cfg(c);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_pixel = {16'sd4, 16'sd3}; in_weight = {16'sd6, 16'sd5};
    @(negedge clk);
    in_valid = 1'b0;
    wait_cyc = 0;
    while (!out_valid && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("bp_out_valid_seen", out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      check_vec($sformatf("bp_hold_data%0d", k), out_data, {16'sd24, 16'sd15});
      check($sformatf("bp_hold_inrdy%0d", k), in_ready, 0);
      @(negedge clk);
    end
    check("bp_still_valid", out_valid, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_done", done, 1);

    // Reset while accumulating: everything clears, nothing from the old job appears.
    c.n_acc = 3;
    @(negedge clk);
    drive_cfg(c);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_pixel = {16'sd9, 16'sd9}; in_weight = {16'sd9, 16'sd9};
    @(negedge clk);
    in_valid = 1'b0;
    held = out_data;
    check("rst_precond_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_in_ready", in_ready, 0);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_done", done, 0);
    check_vec("rst_mid_out_data", out_data, '0);
    rst = 1'b0;
    quiet = 1'b1;
    out_ready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (out_valid || busy || done) quiet = 1'b0;
    end
    out_ready = 1'b0;
    check("rst_no_stale_output", quiet, 1);
    load_vec(tbl[0]);
    run_job(tbl[0].c, "after_reset", 100, 0);

    // Randomized jobs against the reference model.
    for (int j = 0; j < 20; j++) begin
      c.n_acc   = $urandom_range(4);
      c.n_out   = $urandom_range(3);
      c.maxpool = 1'($urandom_range(1));
      c.mp_win  = $urandom_range(4);
      c.bias    = 1'($urandom_range(1));
      c.leaky   = 1'($urandom_range(1));
      c.bypass  = ($urandom_range(4) == 0);
      c.shift   = $urandom_range(10);
      nb = eff_nout(c) * eff_mpw(c) * eff_nacc(c);
      q_pix.delete(); q_wt.delete(); q_bias.delete();
      for (int k = 0; k < nb; k++) begin
        logic [NW-1:0] p, w, b;
        for (int l = 0; l < NL; l++) begin
          p[l*DW +: DW] = DW'(rand_val());
          w[l*DW +: DW] = DW'(rand_val());
          b[l*DW +: DW] = DW'(rand_val());
        end
        q_pix.push_back(p); q_wt.push_back(w); q_bias.push_back(b);
      end
      build_expect(c);
      run_job(c, $sformatf("rand%0d", j), 60, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
